// File: rtl/nco_tune_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nco_tune_ctrl
// Purpose  : Tuning sequencer for the NCO phase increment (angle_incr).
//            Runs host commands (immediate SET, linear GLIDE to a target,
//            repeating SCAN between the current and a target value, STOP).
//            Also reports when the NCO output has settled after each change.
// Ports    : clk, rst (async, active-low)
//            cmd_valid/cmd_ready, cmd_op, cmd_freq, cmd_step, cmd_dwell
//                - command port; cmd_ready is always 1
//            angle_incr - registered phase increment to the NCO
//            busy       - high while a GLIDE/SCAN ramp is running
//            tick       - 1-cycle pulse on every angle_incr change
//            done       - 1-cycle pulse when a GLIDE has finished
//            scan_wrap  - 1-cycle pulse when a SCAN jumps back to its start
//            settled    - SETTLE_CYCLES elapsed since the last change
// Revision : 1.0 - initial release
// ============================================================================
module nco_tune_ctrl #(
    parameter logic [31:0] RESET_INCR    = 32'h0000_0000,
    parameter int          SETTLE_CYCLES = 24            // must be >= 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_freq,
    input  logic [31:0] cmd_step,
    input  logic [15:0] cmd_dwell,
    output logic [31:0] angle_incr,
    output logic        busy,
    output logic        tick,
    output logic        done,
    output logic        scan_wrap,
    output logic        settled
);

    localparam logic [1:0] c_op_set   = 2'b00;
    localparam logic [1:0] c_op_glide = 2'b01;
    localparam logic [1:0] c_op_scan  = 2'b10;

    localparam int             c_sw          = $clog2(SETTLE_CYCLES + 1);
    localparam logic [c_sw-1:0] c_settle_init = c_sw'(SETTLE_CYCLES);
    localparam logic [c_sw-1:0] c_settle_one  = c_sw'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RAMP = 1'b1
    } state_t;

    state_t            r_state,  w_state_nx;
    logic [31:0]       r_incr,   w_incr_nx;
    logic [31:0]       r_target, w_target_nx;
    logic [31:0]       r_start,  w_start_nx;
    logic [31:0]       r_step,   w_step_nx;
    logic [15:0]       r_reload, w_reload_nx;
    logic [15:0]       r_dcnt,   w_dcnt_nx;
    logic              r_mode,   w_mode_nx;   // 1 = SCAN, 0 = GLIDE
    logic              r_dir,    w_dir_nx;    // 1 = counting up
    logic              r_tick;
    logic              r_done,   w_done_nx;
    logic              r_wrap,   w_wrap_nx;
    logic [c_sw-1:0]   r_settle_cnt, w_settle_nx;
    logic              r_settled;

    logic [15:0]       w_dwell_eff;
    logic [31:0]       w_dist;
    logic              w_change;

    assign w_dwell_eff = (cmd_dwell == 16'd0) ? 16'd1 : cmd_dwell;
    // Distance to target computed in both directions so the clip test
    // never relies on wrapping subtraction.
    assign w_dist      = (r_target > r_incr) ? (r_target - r_incr)
                                             : (r_incr - r_target);

    // ------------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nx  = r_state;
        w_incr_nx   = r_incr;
        w_target_nx = r_target;
        w_start_nx  = r_start;
        w_step_nx   = r_step;
        w_reload_nx = r_reload;
        w_dcnt_nx   = r_dcnt;
        w_mode_nx   = r_mode;
        w_dir_nx    = r_dir;
        w_done_nx   = 1'b0;
        w_wrap_nx   = 1'b0;

        if (cmd_valid) begin
            // A command always wins over a ramp step due in the same cycle.
            case (cmd_op)
                c_op_set: begin
                    w_incr_nx  = cmd_freq;
                    w_state_nx = S_IDLE;
                end
                c_op_glide, c_op_scan: begin
                    w_start_nx  = r_incr;
                    w_target_nx = cmd_freq;
                    w_step_nx   = cmd_step;
                    w_reload_nx = w_dwell_eff;
                    w_dcnt_nx   = w_dwell_eff - 16'd1;
                    w_mode_nx   = (cmd_op == c_op_scan);
                    w_dir_nx    = (cmd_freq > r_incr);
                    if ((cmd_step == 32'd0) || (cmd_freq == r_incr)) begin
                        // Degenerate ramp: jump straight there.
                        w_incr_nx  = cmd_freq;
                        w_state_nx = S_IDLE;
                        w_done_nx  = (cmd_op == c_op_glide);
                    end else begin
                        w_state_nx = S_RAMP;
                    end
                end
                default: begin
                    // STOP: hold the current increment.
                    w_state_nx = S_IDLE;
                end
            endcase
        end else if (r_state == S_RAMP) begin
            if (r_dcnt != 16'd0) begin
                w_dcnt_nx = r_dcnt - 16'd1;
            end else begin
                w_dcnt_nx = r_reload - 16'd1;
                if (r_incr != r_target) begin
                    if (w_dist <= r_step) begin
                        w_incr_nx = r_target;
                    end else if (r_dir) begin
                        w_incr_nx = r_incr + r_step;
                    end else begin
                        w_incr_nx = r_incr - r_step;
                    end
                end else if (r_mode) begin
                    w_incr_nx = r_start;
                    w_wrap_nx = 1'b1;
                end else begin
                    // Final value has been held for a full dwell period.
                    w_done_nx  = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
        end
    end

    assign w_change    = (w_incr_nx != r_incr);
    assign w_settle_nx = w_change ? c_settle_init :
                         (r_settle_cnt == '0) ? '0 : (r_settle_cnt - c_settle_one);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_incr       <= RESET_INCR;
            r_target     <= 32'd0;
            r_start      <= 32'd0;
            r_step       <= 32'd0;
            r_reload     <= 16'd1;
            r_dcnt       <= 16'd0;
            r_mode       <= 1'b0;
            r_dir        <= 1'b0;
            r_tick       <= 1'b0;
            r_done       <= 1'b0;
            r_wrap       <= 1'b0;
            r_settle_cnt <= c_settle_init;
            r_settled    <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_incr       <= w_incr_nx;
            r_target     <= w_target_nx;
            r_start      <= w_start_nx;
            r_step       <= w_step_nx;
            r_reload     <= w_reload_nx;
            r_dcnt       <= w_dcnt_nx;
            r_mode       <= w_mode_nx;
            r_dir        <= w_dir_nx;
            r_tick       <= w_change;
            r_done       <= w_done_nx;
            r_wrap       <= w_wrap_nx;
            r_settle_cnt <= w_settle_nx;
            // Registered from the next count so settled rises on the same
            // edge the counter reaches zero.
            r_settled    <= (w_settle_nx == '0);
        end
    end

    assign cmd_ready  = 1'b1;
    assign angle_incr = r_incr;
    assign busy       = (r_state == S_RAMP);
    assign tick       = r_tick;
    assign done       = r_done;
    assign scan_wrap  = r_wrap;
    assign settled    = r_settled;

endmodule
`default_nettype wire

// File: tb/tb_nco_tune_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nco_tune_ctrl
// Purpose  : Self-checking bench for nco_tune_ctrl (directed vectors).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nco_tune_ctrl;

    localparam logic [1:0] c_set   = 2'b00;
    localparam logic [1:0] c_glide = 2'b01;
    localparam logic [1:0] c_scan  = 2'b10;
    localparam logic [1:0] c_stop  = 2'b11;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_freq;
    logic [31:0] cmd_step;
    logic [15:0] cmd_dwell;
    logic [31:0] angle_incr;
    logic        busy;
    logic        tick;
    logic        done;
    logic        scan_wrap;
    logic        settled;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] freq;
        logic [31:0] step;
        logic [15:0] dwell;
        logic [31:0] e_incr;
        logic        e_tick;
        logic        e_done;
        logic        e_busy;
    } vec_t;

    vec_t vecs [9];

    nco_tune_ctrl #(
        .RESET_INCR    (32'h0000_0000),
        .SETTLE_CYCLES (24)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_freq   (cmd_freq),
        .cmd_step   (cmd_step),
        .cmd_dwell  (cmd_dwell),
        .angle_incr (angle_incr),
        .busy       (busy),
        .tick       (tick),
        .done       (done),
        .scan_wrap  (scan_wrap),
        .settled    (settled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [31:0] e_incr, input logic e_tick,
                           input logic e_done, input logic e_wrap, input logic e_busy);
        chk32({nm, " angle_incr"}, angle_incr, e_incr);
        chk1({nm, " tick"}, tick, e_tick);
        chk1({nm, " done"}, done, e_done);
        chk1({nm, " scan_wrap"}, scan_wrap, e_wrap);
        chk1({nm, " busy"}, busy, e_busy);
    endtask

    task automatic step1();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] freq,
                        input logic [31:0] stp, input logic [15:0] dwell);
        cmd_op    = op;
        cmd_freq  = freq;
        cmd_step  = stp;
        cmd_dwell = dwell;
        cmd_valid = 1'b1;
        step1();
        cmd_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] e_incr;
        int          m;

        vecs[0] = '{c_set,   32'h4000_0000, 32'h0, 16'd1, 32'h4000_0000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{c_glide, 32'h0000_1234, 32'h0, 16'd4, 32'h0000_1234, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{c_glide, 32'h0000_1234, 32'h5, 16'd4, 32'h0000_1234, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{c_scan,  32'h0000_1234, 32'h7, 16'd4, 32'h0000_1234, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{c_scan,  32'h0000_0005, 32'h0, 16'd4, 32'h0000_0005, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{c_glide, 32'h0000_0100, 32'h1, 16'd9, 32'h0000_0005, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{c_stop,  32'h0000_0777, 32'h1, 16'd9, 32'h0000_0005, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{c_scan,  32'h0000_0009, 32'h2, 16'd5, 32'h0000_0005, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{c_set,   32'h0000_0000, 32'h0, 16'd1, 32'h0000_0000, 1'b1, 1'b0, 1'b0};

        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_freq  = 32'h0;
        cmd_step  = 32'h0;
        cmd_dwell = 16'h0;

        // ---- reset state and settle timing after release ----
        step1(); step1(); step1();
        chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk1("reset settled", settled, 1'b0);
        chk1("cmd_ready", cmd_ready, 1'b1);
        rst = 1'b1;
        for (int i = 0; i < 23; i++) step1();
        chk1("settle after 23", settled, 1'b0);
        step1();
        chk1("settle after 24", settled, 1'b1);
        chk32("reset incr held", angle_incr, 32'h0);

        // ---- SET with settle tracking ----
        send(c_set, 32'h4000_0000, 32'h0, 16'd1);
        chk_all("set", 32'h4000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk1("set settled low", settled, 1'b0);
        for (int i = 0; i < 23; i++) step1();
        chk1("set settle 23", settled, 1'b0);
        chk1("set tick gone", tick, 1'b0);
        step1();
        chk1("set settle 24", settled, 1'b1);

        // ---- single-command vector table ----
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].op, vecs[i].freq, vecs[i].step, vecs[i].dwell);
            chk_all($sformatf("vec%0d", i), vecs[i].e_incr, vecs[i].e_tick,
                    vecs[i].e_done, 1'b0, vecs[i].e_busy);
        end

        // ---- GLIDE up 0 -> 0x350, step 0x100, dwell 3 ----
        send(c_glide, 32'h350, 32'h100, 16'd3);
        for (int k = 0; k < 18; k++) begin
            if (k > 0) step1();
            e_incr = (k < 12) ? 32'(k / 3) * 32'h100 : 32'h350;
            chk_all($sformatf("glide_up k=%0d", k), e_incr,
                    (k == 3 || k == 6 || k == 9 || k == 12), (k == 15), 1'b0, (k < 15));
        end

        // ---- GLIDE down 0x350 -> 0 ----
        send(c_glide, 32'h0, 32'h100, 16'd3);
        for (int k = 0; k < 18; k++) begin
            if (k > 0) step1();
            e_incr = (k < 12) ? 32'h350 - 32'(k / 3) * 32'h100 : 32'h0;
            chk_all($sformatf("glide_dn k=%0d", k), e_incr,
                    (k == 3 || k == 6 || k == 9 || k == 12), (k == 15), 1'b0, (k < 15));
        end

        // ---- SCAN 0x1000 <-> 0x1300, step 0x100, dwell 2, then STOP ----
        send(c_set, 32'h1000, 32'h0, 16'd1);
        chk32("scan pre-set", angle_incr, 32'h1000);
        send(c_scan, 32'h1300, 32'h100, 16'd2);
        for (int k = 0; k < 22; k++) begin
            if (k > 0) step1();
            m = k % 8;
            e_incr = 32'h1000 + 32'(m / 2) * 32'h100;
            chk_all($sformatf("scan k=%0d", k), e_incr,
                    (k > 0 && (m % 2) == 0), 1'b0, (k > 0 && m == 0), 1'b1);
        end
        // STOP lands on the edge where 0x1300 would otherwise be applied
        send(c_stop, 32'h0, 32'h0, 16'd0);
        chk_all("stop", 32'h1200, 1'b0, 1'b0, 1'b0, 1'b0);
        step1(); step1(); step1();
        chk_all("stop hold", 32'h1200, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---- preemption on a dwell-expiry cycle ----
        send(c_set, 32'h0, 32'h0, 16'd1);
        send(c_glide, 32'h350, 32'h100, 16'd3);
        step1(); step1();
        chk_all("preempt pre", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(c_set, 32'h0, 32'h0, 16'd1);
        chk_all("preempt", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step1();
            chk_all($sformatf("preempt after %0d", k), 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // ---- dwell=0 behaves as dwell=1 ----
        send(c_glide, 32'h3, 32'h1, 16'd0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step1();
            e_incr = (k < 3) ? 32'(k) : 32'h3;
            chk_all($sformatf("dwell0 k=%0d", k), e_incr,
                    (k >= 1 && k <= 3), (k == 4), 1'b0, (k < 4));
        end

        // ---- full-range ramp clips without overflow ----
        send(c_set, 32'h0, 32'h0, 16'd1);
        send(c_glide, 32'hFFFF_FFFF, 32'h8000_0000, 16'd1);
        chk_all("big k=0", 32'h0,         1'b0, 1'b0, 1'b0, 1'b1);
        step1();
        chk_all("big k=1", 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
        step1();
        chk_all("big k=2", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        step1();
        chk_all("big k=3", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);

        // ---- asynchronous reset during a ramp ----
        send(c_glide, 32'h1000, 32'h1, 16'd1);
        step1(); step1();
        chk_all("ramp before rst", 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk_all("async rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk1("async rst settled", settled, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step1(); step1(); step1();
        chk_all("after rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nco_tune_ctrl.md
Name: nco_tune_ctrl

Overview:
Tuning sequencer that drives the 32-bit phase increment (angle_incr) of the radio's NCO. It accepts commands over a valid/ready port:
- immediate set
- linear glide to a target
- repeating scan between the current and a target frequency
It also reports when the NCO pipeline output has settled after each change. It sits between the host command decoder and the nco instance.

Parameters:
RESET_INCR, 32'h00000000, angle_incr value after reset
SETTLE_CYCLES, 24, cycles after any angle_incr change before NCO sin/cos output is valid (covers NCO pipeline latency plus margin); must be >= 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at posedge clk
cmd_op  in  2  00 SET, 01 GLIDE, 10 SCAN, 11 STOP
cmd_freq  in  32  target angle increment (SET/GLIDE/SCAN)
cmd_step  in  32  unsigned step magnitude (GLIDE/SCAN)
cmd_dwell  in  16  cycles per step point (GLIDE/SCAN); 0 treated as 1
angle_incr  out  32  registered increment to NCO
busy  out  1  1 while in RAMP state
tick  out  1  1-cycle pulse on every angle_incr change
done  out  1  1-cycle pulse when GLIDE reaches target
scan_wrap  out  1  1-cycle pulse when SCAN returns to start
settled  out  1  1 when SETTLE_CYCLES have elapsed since last angle_incr change

Behaviour:
- Reset (rst=0, async):
  - angle_incr=RESET_INCR, state IDLE, busy=0, tick=done=scan_wrap=0.
  - Settle counter=SETTLE_CYCLES, settled=0.
- cmd_ready is constant 1. A new command in any state preempts the current one.
- States: IDLE, RAMP. Registers: target, start, step, dwell_reload, dwell_cnt[15:0], mode (GLIDE/SCAN), dir (up/down).
- Command accepted at edge N:
  - SET: angle_incr<=cmd_freq; tick=1 in cycle after N only if value differs; state IDLE.
  - GLIDE/SCAN:
    - start<=angle_incr, target<=cmd_freq, step<=cmd_step.
    - dwell_reload<=max(cmd_dwell,1), dwell_cnt<=max(cmd_dwell,1)-1.
    - dir<=(cmd_freq>angle_incr), unsigned compare; state RAMP.
    - If cmd_step==0 or cmd_freq==angle_incr: behaves as SET, then GLIDE pulses done; SCAN goes to IDLE without done.
  - STOP: state IDLE, angle_incr held, no pulses.
- RAMP, dwell_cnt!=0: decrement.
- RAMP, dwell_cnt==0: reload dwell_cnt=dwell_reload-1, then:
  - If angle_incr!=target:
    - If |target-angle_incr| <= step: angle_incr<=target (no overshoot).
    - Else angle_incr<=angle_incr±step per dir; tick.
    - Arithmetic is unsigned 32-bit; no wrap past target is possible.
  - If angle_incr==target:
    - GLIDE: done pulse, state IDLE. The final value was applied one dwell period earlier, so done fires after a full dwell at target.
    - SCAN: angle_incr<=start, tick, scan_wrap pulse, stay RAMP.
- Command acceptance and an internal step in the same cycle: the command wins; the step is discarded.
- Settle counter:
  - Reloads to SETTLE_CYCLES on every cycle angle_incr changes.
  - Otherwise decrements to 0, saturating.
  - settled=(counter==0), registered.
- All outputs registered. tick/done/scan_wrap assert the cycle after the edge that updates state.
- Reset mid-ramp returns to the reset values immediately; no pending command survives.

Test Plan:
- Reset: hold rst=0 then release → angle_incr=0, busy=0, settled rises exactly 24 cycles after release.
- SET 0x40000000 → angle_incr=0x40000000 next cycle, one tick, settled low 24 cycles then high; repeat SET same value → no tick.
- GLIDE from 0, freq=0x350, step=0x100, dwell=3 → angle_incr 0x100,0x200,0x300,0x350 at 3-cycle spacing, done 3 cycles after 0x350, busy falls with done; downward GLIDE 0x350→0 mirrors.
- SCAN from 0x1000, freq=0x1300, step=0x100, dwell=2 → 0x1100,0x1200,0x1300, then 0x1000 with scan_wrap, repeats until STOP; STOP holds current value, busy=0.
- Preemption: GLIDE in progress, SET 0x0 issued on a dwell-expiry cycle → angle_incr=0, no step applied, no done, busy=0.
- Edge values: dwell=0 behaves as dwell=1; step=0 GLIDE acts as SET plus done; ramp 0→0xFFFFFFFF with step 0x80000000 clips to 0xFFFFFFFF without overflow; async reset during RAMP restores reset values.
